// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared definitions for the LDPC column-memory scheduler.
//   - default circulant size, LLR width and address width
//   - scheduler state encoding
//   - modulo-Z wrap helper used for both the start offset and the
//     cyclic address generators
package ldpc_pkg;

  localparam int Z_DEF            = 511;
  localparam int W_DEF            = 6;
  localparam int COLADDR_BITS_DEF = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  // Single conditional subtraction: callers guarantee sum < 2*z.
  function automatic logic [31:0] wrap_mod_z(input logic [31:0] sum,
                                             input logic [31:0] z);
    logic [31:0] res;
    if (sum >= z) begin
      res = sum - z;
    end else begin
      res = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/ldpc_cyc_addr_gen.sv
// ldpc_cyc_addr_gen: cyclic address for one position of a circulant pass.
//   i_base : COLADDR_BITS  wrapped start offset (always < Z)
//   i_idx  : COLADDR_BITS  sequence index (always < Z when used)
//   o_addr : COLADDR_BITS  (i_base + i_idx) mod Z, never >= Z
module ldpc_cyc_addr_gen
  import ldpc_pkg::*;
#(
  parameter int Z            = Z_DEF,
  parameter int COLADDR_BITS = COLADDR_BITS_DEF
) (
  input  logic [COLADDR_BITS-1:0] i_base,
  input  logic [COLADDR_BITS-1:0] i_idx,
  output logic [COLADDR_BITS-1:0] o_addr
);

  logic [COLADDR_BITS:0]    w_sum;
  logic [31:0]              w_wrap;
  logic [31-COLADDR_BITS:0] w_unused_hi;

  // One extra bit so base + idx (both < Z) cannot overflow before the wrap.
  assign w_sum  = {1'b0, i_base} + {1'b0, i_idx};
  assign w_wrap = wrap_mod_z(32'(w_sum), 32'(Z));
  // The wrapped value is < Z, so the upper bits are always zero.
  assign {w_unused_hi, o_addr} = w_wrap;

endmodule

// File: rtl/ldpc_colmem_sched.sv
// ldpc_colmem_sched: sequences one pass over a Z-deep column LLR memory.
//   memclk   in   clock, all state on posedge
//   rst      in   asynchronous active-low reset
//   start    in   one-cycle start pulse (IDLE only); shift latched with it
//   shift    in   cyclic offset (shift >= Z is folded once)
//   busy     out  high from the cycle after start until done
//   done     out  one-cycle pulse, co-incident with the last write
//   ra/rd_en out  RAM read address / enable
//   rd_valid out  RAM DOUT valid this cycle; rd_idx is its sequence index
//   wb_valid in   processing unit result strobe; wb_data its word
//   wa/wr_en/din out  RAM write address / enable / data
//   overflow out  sticky: a write-back was dropped (cleared by start)
module ldpc_colmem_sched
  import ldpc_pkg::*;
#(
  parameter int Z            = Z_DEF,
  parameter int W            = W_DEF,
  parameter int COLADDR_BITS = COLADDR_BITS_DEF
) (
  input  logic                    memclk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [COLADDR_BITS-1:0] shift,
  output logic                    busy,
  output logic                    done,
  output logic [COLADDR_BITS-1:0] ra,
  output logic                    rd_en,
  output logic                    rd_valid,
  output logic [COLADDR_BITS-1:0] rd_idx,
  input  logic                    wb_valid,
  input  logic [W-1:0]            wb_data,
  output logic [COLADDR_BITS-1:0] wa,
  output logic                    wr_en,
  output logic [W-1:0]            din,
  output logic                    overflow
);

  localparam int AB = COLADDR_BITS;
  // Counters carry one extra bit so they can hold the value Z.
  localparam logic [AB:0] CNT_ONE  = (AB+1)'(1);
  localparam logic [AB:0] CNT_LAST = (AB+1)'(Z - 1);

  sched_state_e   r_state;
  logic [AB-1:0]  r_base;
  logic [AB:0]    r_rd_cnt;
  logic [AB:0]    r_wr_cnt;
  logic [AB-1:0]  r_issue_idx;
  logic           r_busy, r_done, r_rd_en, r_rd_valid, r_wr_en, r_overflow;
  logic [AB-1:0]  r_ra, r_rd_idx, r_wa;
  logic [W-1:0]   r_din;

  logic [AB-1:0]  w_rd_addr, w_wr_addr, w_shift_wrapped;
  logic [31:0]    w_shift_full;
  logic [31-AB:0] w_unused_shift_hi;
  logic           w_wb_accept;

  assign w_shift_full = wrap_mod_z(32'(shift), 32'(Z));
  assign {w_unused_shift_hi, w_shift_wrapped} = w_shift_full;

  ldpc_cyc_addr_gen #(.Z(Z), .COLADDR_BITS(AB)) u_rd_addr (
    .i_base (r_base),
    .i_idx  (r_rd_cnt[AB-1:0]),
    .o_addr (w_rd_addr)
  );

  ldpc_cyc_addr_gen #(.Z(Z), .COLADDR_BITS(AB)) u_wr_addr (
    .i_base (r_base),
    .i_idx  (r_wr_cnt[AB-1:0]),
    .o_addr (w_wr_addr)
  );

  // A write-back may only target an address that has already been read,
  // which keeps writes strictly behind reads on the same address sequence.
  assign w_wb_accept = wb_valid && ((r_state == RUN) || (r_state == WB)) &&
                       (r_wr_cnt < r_rd_cnt);

  // Sequencer: state, counters and every RAM-side output register.
  always_ff @(posedge memclk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_issue_idx <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_overflow  <= 1'b0;
      r_ra        <= '0;
      r_rd_idx    <= '0;
      r_wa        <= '0;
      r_din       <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rd_valid <= r_rd_en;
      if (r_rd_en) begin
        r_rd_idx <= r_issue_idx;
      end
      if (w_wb_accept) begin
        r_wr_en  <= 1'b1;
        r_wa     <= w_wr_addr;
        r_din    <= wb_data;
        r_wr_cnt <= r_wr_cnt + CNT_ONE;
      end else if (wb_valid) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base     <= w_shift_wrapped;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_rd_en     <= 1'b1;
          r_ra        <= w_rd_addr;
          r_issue_idx <= r_rd_cnt[AB-1:0];
          r_rd_cnt    <= r_rd_cnt + CNT_ONE;
          if (r_rd_cnt == CNT_LAST) begin
            r_state <= WB;
          end
        end
        WB: begin
          // The Z-th write can only be accepted here: in RUN the read
          // count is still below Z.
          if (w_wb_accept && (r_wr_cnt == CNT_LAST)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign ra       = r_ra;
  assign rd_en    = r_rd_en;
  assign rd_valid = r_rd_valid;
  assign rd_idx   = r_rd_idx;
  assign wa       = r_wa;
  assign wr_en    = r_wr_en;
  assign din      = r_din;
  assign overflow = r_overflow;

endmodule
